// File: rtl/deck_shuffler_if.sv
// Deck request/response bundle between the hand FSM (master) and the
// deck shuffler (slave). Cards are packed {rank[3:0], suit[1:0]}.
interface deck_shuffler_if;
    logic       start_shuffle;
    logic       draw_card;
    logic [5:0] top_card;
    logic       ready;
    logic [5:0] cards_left;
    logic       empty;

    modport master (
        output start_shuffle, draw_card,
        input  top_card, ready, cards_left, empty
    );

    modport slave (
        input  start_shuffle, draw_card,
        output top_card, ready, cards_left, empty
    );
endinterface

// File: rtl/deck_shuffler.sv
// 52-card deck: rebuilds the ordered deck, Fisher-Yates shuffles it with a
// free-running LFSR (rejection sampling on a power-of-two mask), then serves
// one card per draw on the top_card output.
module deck_shuffler #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    deck_shuffler_if.slave  bus
);
    typedef logic [5:0] card_t;  // {rank[3:0], suit[1:0]}
    typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, READY} state_t;

    // An all-zero Fibonacci LFSR never leaves zero, so substitute 1.
    localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam card_t       ACE_SPADES = 6'b1110_11;
    localparam logic [5:0]  LAST_IDX   = 6'd51;
    localparam logic [5:0]  DECK_SIZE  = 6'd52;

    state_t      state, next_state;
    logic [15:0] lfsr;
    logic [5:0]  k;      // INIT write index
    logic [5:0]  i;      // SHUFFLE position being finalised
    logic [5:0]  ptr;    // draw pointer, 0..52
    card_t       deck [52];

    logic        init_wr, do_swap, do_pop;
    logic [5:0]  mask, r;
    logic        r_ok;

    // Free-running LFSR; advances every cycle so the shuffle depends on request timing.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement or process order.
        if (reset) lfsr <= SEED_EFF;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Candidate swap index: smear i into an all-ones mask, accept only r <= i.
    always_comb begin
        mask = i | (i >> 1) | (i >> 2) | (i >> 3) | (i >> 4) | (i >> 5);
        r    = lfsr[5:0] & mask;
        r_ok = (r <= i);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and datapath strobes; start_shuffle overrides everything.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        init_wr    = 1'b0;
        do_swap    = 1'b0;
        do_pop     = 1'b0;
        if (bus.start_shuffle) begin
            next_state = INIT;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                INIT: begin
                    init_wr = 1'b1;
                    if (k == LAST_IDX) next_state = SHUFFLE;
                end
                SHUFFLE: begin
                    if (r_ok) begin
                        do_swap = 1'b1;
                        if (i == 6'd1) next_state = READY;
                    end
                end
                READY:   do_pop = bus.draw_card && (ptr != DECK_SIZE);
                default: next_state = IDLE;
            endcase
        end
    end

    // Counters: INIT index, shuffle position and draw pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            k   <= 6'd0;
            i   <= 6'd0;
            ptr <= 6'd0;
        end else if (bus.start_shuffle) begin
            k   <= 6'd0;
            ptr <= 6'd0;
        end else begin
            if (init_wr)                    k   <= k + 6'd1;
            if (init_wr && k == LAST_IDX)   i   <= LAST_IDX;
            if (do_swap)                    i   <= i - 6'd1;
            if (do_pop)                     ptr <= ptr + 6'd1;
        end
    end

    // Deck storage: ordered fill during INIT, one two-way swap per accepted draw.
    always_ff @(posedge clk) begin
        // NOTE: the deck array has no reset; INIT fully rewrites it before any
        // entry can be observed, so resetting it would only cost logic.
        if (!reset) begin
            if (init_wr) deck[k] <= {k[5:2] + 4'd2, k[1:0]};
            if (do_swap) begin
                deck[i] <= deck[r];
                deck[r] <= deck[i];
            end
        end
    end

    // Outputs derived from state and the draw pointer.
    always_comb begin
        bus.ready      = (state == READY);
        bus.empty      = bus.ready && (ptr == DECK_SIZE);
        bus.cards_left = bus.ready ? (DECK_SIZE - ptr) : DECK_SIZE;
        bus.top_card   = ACE_SPADES;
        if (bus.ready && ptr != DECK_SIZE) bus.top_card = deck[ptr];
    end
endmodule

// File: tb/tb_deck_shuffler.sv
// Self-checking bench for deck_shuffler: a per-cycle behavioural model
// (LFSR sequence + array Fisher-Yates) feeds a scoreboard queue that a
// monitor drains; a directed driver exercises dealing, empty, restart and
// seed behaviour. A second instance with seed 0 must behave like seed 1.
module tb_deck_shuffler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deck_shuffler_if bus ();
    deck_shuffler_if zbus ();

    deck_shuffler #(.LFSR_SEED(16'hACE1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    deck_shuffler #(.LFSR_SEED(16'h0000)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (zbus)
    );

    assign zbus.start_shuffle = bus.start_shuffle;
    assign zbus.draw_card     = bus.draw_card;

    typedef struct packed {
        logic       ready;
        logic [5:0] top;
        logic [5:0] left;
        logic       empty;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] seed_of(input int u);
        return (u == 0) ? 16'hACE1 : 16'h0001;
    endfunction

    logic [5:0]  tmp_deck [52];
    logic [5:0]  m_deck   [2][52];
    logic [15:0] m_lfsr   [2];
    int          m_phase  [2];   // 0 idle, 1 building, 2 ready
    int          m_busy   [2];
    int          m_ptr    [2];
    int          m_lat    [2];

    // l0 is the LFSR value in the cycle ending at the start edge. Returns the
    // number of edges (start edge included) until ready is visible.
    task automatic compute_shuffle(input logic [15:0] l0, output int lat);
        logic [15:0] l;
        logic [5:0]  t;
        int          idx;
        int          mask;
        int          r;
        for (int c = 0; c < 52; c++) tmp_deck[c] = {4'(c / 4 + 2), 2'(c % 4)};
        l = l0;
        for (int j = 0; j < 53; j++) l = step(l);
        lat = 53;
        idx = 51;
        while (idx >= 1 && lat < 100000) begin
            mask = 1;
            while (mask < idx) mask = mask * 2 + 1;
            r = int'(l[5:0]) & mask;
            lat++;
            if (r <= idx) begin
                t             = tmp_deck[idx];
                tmp_deck[idx] = tmp_deck[r];
                tmp_deck[r]   = t;
                idx--;
            end
            l = step(l);
        end
    endtask

    always @(posedge clk) begin
        int   lat;
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (reset) begin
                m_lfsr[u]  = seed_of(u);
                m_phase[u] = 0;
                m_ptr[u]   = 0;
            end else begin
                if (bus.start_shuffle) begin
                    compute_shuffle(m_lfsr[u], lat);
                    for (int c = 0; c < 52; c++) m_deck[u][c] = tmp_deck[c];
                    m_lat[u]   = lat;
                    m_busy[u]  = lat - 1;
                    m_phase[u] = 1;
                    m_ptr[u]   = 0;
                end else if (m_phase[u] == 1) begin
                    m_busy[u]--;
                    if (m_busy[u] == 0) m_phase[u] = 2;
                end else if (m_phase[u] == 2 && bus.draw_card && m_ptr[u] < 52) begin
                    m_ptr[u]++;
                end
                m_lfsr[u] = step(m_lfsr[u]);
            end
            e.ready = (m_phase[u] == 2);
            e.left  = e.ready ? 6'(52 - m_ptr[u]) : 6'd52;
            e.empty = e.ready && (m_ptr[u] == 52);
            e.top   = (e.ready && m_ptr[u] < 52) ? m_deck[u][m_ptr[u]] : 6'b1110_11;
            if (u == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                check("ready",      bus.ready,      e.ready);
                check("top_card",   bus.top_card,   e.top);
                check("cards_left", bus.cards_left, e.left);
                check("empty",      bus.empty,      e.empty);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check("seed0_ready",      zbus.ready,      e.ready);
                check("seed0_top_card",   zbus.top_card,   e.top);
                check("seed0_cards_left", zbus.cards_left, e.left);
                check("seed0_empty",      zbus.empty,      e.empty);
            end
        end
    end

    // ---------------- driver ----------------
    logic [5:0] exp_seq1 [52];
    logic [5:0] dealt    [52];

    task automatic pulse_start(input logic with_draw);
        @(negedge clk);
        bus.start_shuffle = 1'b1;
        bus.draw_card     = with_draw;
        @(negedge clk);
        bus.start_shuffle = 1'b0;
        bus.draw_card     = 1'b0;
    endtask

    // Called right after pulse_start; counts edges from the start edge.
    task automatic wait_ready(input logic rand_draws, output int n);
        n = 1;
        while (!bus.ready && n < 3000) begin
            bus.draw_card = rand_draws ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
        end
        bus.draw_card = 1'b0;
        check("ready_rose", bus.ready, 1);
    endtask

    task automatic full_deal(input int max_gap);
        logic seen [64];
        logic [5:0] c;
        for (int s = 0; s < 64; s++) seen[s] = 1'b0;
        for (int n = 0; n < 52; n++) begin
            check("deal_cards_left", bus.cards_left, 52 - n);
            c = bus.top_card;
            dealt[n] = c;
            check("card_valid", (c[5:2] >= 4'd2 && c[5:2] <= 4'd14), 1);
            check("card_distinct", seen[c], 0);
            seen[c] = 1'b1;
            bus.draw_card = 1'b1;
            @(negedge clk);
            bus.draw_card = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        check("deal_empty", bus.empty, 1);
        check("deal_left_zero", bus.cards_left, 0);
    endtask

    initial begin
        int n;
        int d;
        reset             = 1'b1;
        bus.start_shuffle = 1'b0;
        bus.draw_card     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle: nothing happens without a start request.
        repeat (10) @(negedge clk);
        check("idle_ready", bus.ready, 0);
        check("idle_left",  bus.cards_left, 52);
        check("idle_top",   bus.top_card, 6'b111011);

        // First shuffle and full deal.
        d = $urandom_range(0, 5);
        repeat (d) @(negedge clk);
        pulse_start(1'b0);
        wait_ready(1'b0, n);
        check("latency", n, m_lat[0]);
        check("latency_min", (n >= 104), 1);
        for (int c = 0; c < 52; c++) exp_seq1[c] = m_deck[0][c];
        full_deal(0);

        // Draws while empty are ignored.
        bus.draw_card = 1'b1;
        repeat (5) @(negedge clk);
        bus.draw_card = 1'b0;
        check("empty_left",  bus.cards_left, 0);
        check("empty_top",   bus.top_card, 6'b111011);
        check("empty_ready", bus.ready, 1);

        // Partial deal, then restart with draw asserted in the same cycle.
        pulse_start(1'b0);
        wait_ready(1'b1, n);
        check("restart_left_full", bus.cards_left, 52);
        bus.draw_card = 1'b1;
        repeat (7) @(negedge clk);
        bus.draw_card = 1'b0;
        check("partial_left", bus.cards_left, 45);
        pulse_start(1'b1);
        check("restart_ready_drop", bus.ready, 0);
        check("restart_left", bus.cards_left, 52);
        wait_ready(1'b1, n);
        check("restart_latency", n, m_lat[0]);
        check("post_ready_left", bus.cards_left, 52);
        full_deal(2);

        // Same seed, same timing after reset: same sequence as the first run.
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        repeat (d) @(negedge clk);
        pulse_start(1'b0);
        wait_ready(1'b0, n);
        full_deal(0);
        for (int c = 0; c < 52; c++) check("repeat_seq", dealt[c], exp_seq1[c]);

        // Seed-0 instance must also reach ready.
        n = 0;
        while (!zbus.ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("seed0_ready_end", zbus.ready, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
